// File: rtl/bus_uart.sv
// rtl/bus_uart.sv - memory-mapped 8N1 UART bus slave
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   din, addr, we bus write data, word address (addr[1:0] decoded), write enable
//   dout          registered read data, one-cycle latency
//   uart_rx       asynchronous serial input, idle high
//   uart_tx       registered serial output, idle high
// Register map: 0 TXDATA, 1 RXDATA (RO), 2 STATUS, 3 DIV.
module bus_uart #(
  parameter int DW      = 16,
  parameter int AW      = 12,
  parameter int DIV_RST = 434
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic [DW-1:0] dout,
  input  logic          uart_rx,
  output logic          uart_tx
);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [15:0] div;
  logic [15:0] period;
  logic [15:0] half;
  logic [7:0]  tx_data;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;

  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;

  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_d;

  logic        tx_busy;
  logic        rx_done;
  logic        wr_tx;
  logic        wr_stat;
  logic        wr_div;
  logic        unused_addr;

  // Bit periods shorter than 4 clocks are clamped so the half-period
  // start-bit sample point never collapses to zero.
  assign period      = (div < 16'd4) ? 16'd4 : div;
  assign half        = {1'b0, period[15:1]};
  assign tx_busy     = (tx_state != TX_IDLE);
  assign wr_tx       = we && (addr[1:0] == 2'd0) && !tx_busy;
  assign wr_stat     = we && (addr[1:0] == 2'd2);
  assign wr_div      = we && (addr[1:0] == 2'd3);
  assign rx_done     = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
  assign unused_addr = ^addr[AW-1:2];

  // Read path: plain mux of current state, no read side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else begin
      case (addr[1:0])
        2'd0:    dout <= DW'(tx_data);
        2'd1:    dout <= DW'(rx_data);
        2'd2:    dout <= DW'({frame_err, rx_overrun, rx_valid, tx_busy});
        default: dout <= DW'(div);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= 16'(DIV_RST);
    end else if (wr_div) begin
      div <= din[15:0];
    end
  end

  // Transmitter. The counter is reloaded from the live divisor at every
  // bit boundary; uart_tx follows the state one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_data  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr_tx) begin
            tx_data  <= din[7:0];
            tx_cnt   <= period - 16'd1;
            tx_bit   <= '0;
            tx_state <= TX_START;
          end
        end
        default: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt <= period - 16'd1;
            case (tx_state)
              TX_START: tx_state <= TX_DATA;
              TX_DATA: begin
                tx_bit <= tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state <= TX_STOP;
              end
              default:  tx_state <= TX_IDLE;
            endcase
          end
        end
      endcase

      case (tx_state)
        TX_START: uart_tx <= 1'b0;
        TX_DATA:  uart_tx <= tx_data[tx_bit];
        default:  uart_tx <= 1'b1;
      endcase
    end
  end

  // Receiver. rx_d holds the previous synchronized sample for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_cnt   <= half - 16'd1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rx_s2) begin
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt   <= period - 16'd1;
            rx_bit   <= '0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= period - 16'd1;
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end
        end
        default: begin
          // Leave at the stop midpoint so a new start edge in the rest of
          // the stop bit is still caught.
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Status flags: W1C from software, hardware set takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_done) rx_data <= rx_shift;
      rx_valid   <= (rx_valid   & ~(wr_stat & din[1])) | rx_done;
      rx_overrun <= (rx_overrun & ~(wr_stat & din[2])) | (rx_done & rx_valid);
      frame_err  <= (frame_err  & ~(wr_stat & din[3])) | (rx_done & ~rx_s2);
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// tb/tb_bus_uart.sv - directed self-checking bench for bus_uart
`timescale 1ns/1ps
module tb_bus_uart;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic [11:0] addr;
  logic        we;
  logic [15:0] dout;
  logic        uart_rx;
  logic        uart_tx;
  logic        loop;
  logic        rx_line;

  int total;
  int bad;

  logic [15:0] rd;
  logic [9:0]  f;

  bus_uart #(.DW(16), .AW(12), .DIV_RST(434)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .addr    (addr),
    .we      (we),
    .dout    (dout),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  assign uart_rx = loop ? uart_tx : rx_line;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a;
    we   = 1'b0;
    @(negedge clk);
    d = dout;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rx_line = fr[k];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    rx_line = 1'b1;
    repeat (31) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    din     = '0;
    addr    = '0;
    we      = 1'b0;
    loop    = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_tx_line", uart_tx, 1'b1);
    chk("rst_dout", dout, 16'h0000);
    bus_read(12'd3, rd); chk("rst_div", rd, 16'd434);
    bus_read(12'd2, rd); chk("rst_status", rd, 16'h0000);
    bus_read(12'd0, rd); chk("rst_txdata", rd, 16'h0000);
    bus_read(12'd1, rd); chk("rst_rxdata", rd, 16'h0000);

    // TX frame 0xA5 at P=8, busy tracked through STATUS, write during busy ignored
    bus_write(12'd3, 16'd8);
    bus_read(12'd3, rd); chk("div_rd", rd, 16'd8);
    f = {1'b1, 8'hA5, 1'b0};
    bus_write(12'd0, 16'h00A5);
    addr = 12'd2;
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      chk("tx_line", uart_tx, (i < 80) ? f[i/8] : 1'b1);
      if (i == 41) chk("tx_rd_busy", dout, 16'h00A5);
      else chk("tx_busy", dout[0], (i < 80) ? 1'b1 : 1'b0);
      if (i == 40) begin
        addr = 12'd0; din = 16'h003C; we = 1'b1;
      end else begin
        addr = 12'd2; we = 1'b0;
      end
    end
    bus_read(12'd0, rd); chk("tx_ignored", rd, 16'h00A5);

    // RX loopback 0x5A at P=16
    loop = 1'b1;
    bus_write(12'd3, 16'd16);
    bus_write(12'd0, 16'h005A);
    for (int k = 0; k < 400; k++) begin
      bus_read(12'd2, rd);
      if (rd[1]) break;
    end
    chk("rx_wait", rd[1], 1'b1);
    repeat (20) @(negedge clk);
    bus_read(12'd1, rd); chk("lb_rxdata", rd, 16'h005A);
    bus_read(12'd2, rd); chk("lb_status", rd, 16'h0002);
    bus_write(12'd2, 16'h0002);
    bus_read(12'd2, rd); chk("lb_clear", rd, 16'h0000);
    loop = 1'b0;

    // first frame, repeated reads and aliasing keep rx_valid
    send_rx(8'h11, 1'b1);
    bus_read(12'd1, rd); chk("rx1_data", rd, 16'h0011);
    bus_read(12'd1, rd);
    bus_read(12'd1, rd);
    bus_read(12'd2, rd); chk("rx1_status", rd, 16'h0002);
    bus_read(12'h006, rd); chk("alias_status", rd, 16'h0002);

    // second frame with bad stop bit, overwritten without clearing
    send_rx(8'h22, 1'b0);
    bus_read(12'd1, rd); chk("rx2_data", rd, 16'h0022);
    bus_read(12'd2, rd); chk("rx2_status", rd, 16'h000E);
    bus_write(12'd2, 16'h000E);
    bus_read(12'd2, rd); chk("rx2_clear", rd, 16'h0000);

    // 3-clock glitch is rejected
    @(negedge clk); rx_line = 1'b0;
    repeat (3) @(negedge clk); rx_line = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(12'd2, rd); chk("glitch_status", rd, 16'h0000);

    // DIV=1 clamps to a 4-clock bit period
    bus_write(12'd3, 16'd1);
    f = {1'b1, 8'h33, 1'b0};
    bus_write(12'd0, 16'h0033);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("clamp_line", uart_tx, f[i/4]);
    end
    repeat (4) @(negedge clk);
    bus_read(12'd2, rd); chk("clamp_idle", rd, 16'h0000);

    // asynchronous reset mid-frame
    bus_write(12'd3, 16'd16);
    bus_write(12'd0, 16'h0000);
    addr = 12'd3;
    repeat (30) @(negedge clk);
    chk("pre_rst_line", uart_tx, 1'b0);
    chk("pre_rst_dout", dout, 16'd16);
    #2 rst = 1'b1;
    #1;
    chk("async_tx_line", uart_tx, 1'b1);
    chk("async_dout", dout, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    bus_read(12'd3, rd); chk("post_rst_div", rd, 16'd434);
    bus_read(12'd2, rd); chk("post_rst_status", rd, 16'h0000);
    bus_read(12'd0, rd); chk("post_rst_txdata", rd, 16'h0000);
    repeat (20) @(negedge clk);
    chk("post_rst_line", uart_tx, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
